// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-requester handshake bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_NUM_PER     = 2;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_SYNC_STAGES = 2;

  // Width of a peripheral index; never narrower than one bit.
  function automatic int dest_w(input int num_per);
    return (num_per > 1) ? $clog2(num_per) : 1;
  endfunction

endpackage

// File: rtl/ack_synchronizer.sv
// Multi-stage flop chain bringing the asynchronous peripheral acks into clk.
module ack_synchronizer
  import bus_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_NUM_PER,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the raw ack through STAGES flops; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/handshake_bus_arbiter.sv
// Round-robin arbiter sharing one data bus between two requesters and
// sequencing a four-phase send/ack handshake to the addressed peripheral.
// Requester side: req_valid is a level held until the one-cycle req_ready
// pulse; data and destination are captured on the grant cycle.
module handshake_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_PER     = DEF_NUM_PER,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int DEST_W     = dest_w(NUM_PER)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*DEST_W-1:0] req_dest,
  output logic [1:0]          req_ready,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic                busy,
  output logic [DATA_W-1:0]   dado,
  output logic [NUM_PER-1:0]  send,
  input  logic [NUM_PER-1:0]  ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                last_grant, owner;
  logic [DEST_W-1:0]   dest, dest_sel, dest_nxt;
  logic [DATA_W-1:0]   data_sel;
  logic [NUM_PER-1:0]  ack_s;
  logic                ack_hit, phase_expired;
  logic                grant, gnt_id, fin, timeout;
  logic [NUM_PER-1:0]  send_nxt;
  logic [1:0]          ready_nxt, done_nxt, err_nxt;

  ack_synchronizer #(.WIDTH(NUM_PER), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  assign dest_sel      = gnt_id ? req_dest[DEST_W +: DEST_W] : req_dest[DEST_W-1:0];
  assign data_sel      = gnt_id ? req_data[DATA_W +: DATA_W] : req_data[DATA_W-1:0];
  assign phase_expired = (cnt == CNT_W'(TIMEOUT - 1));

  // Synchronised ack of the current destination; out-of-range dest never acks.
  always_comb begin
    ack_hit = 1'b0;
    for (int i = 0; i < NUM_PER; i++) begin
      if (int'(dest) == i) ack_hit = ack_s[i];
    end
  end

  // State register plus the per-phase counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
    end
  end

  // Next state: arbitration in IDLE, handshake progress and timeouts elsewhere.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_id    = last_grant;
    fin       = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        // A lingering ack from an aborted transfer blocks new grants.
        if ((|req_valid) && !(|ack_s)) begin
          grant     = 1'b1;
          gnt_id    = req_valid[~last_grant] ? ~last_grant : last_grant;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (ack_hit) begin
          state_nxt = RELEASE;
        end else if (phase_expired) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_hit) begin
          state_nxt = IDLE;
          fin       = 1'b1;
        end else if (phase_expired) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    dest_nxt  = grant ? dest_sel : dest;
    send_nxt  = '0;
    ready_nxt = '0;
    done_nxt  = '0;
    err_nxt   = '0;
    for (int i = 0; i < NUM_PER; i++) begin
      if (state_nxt == SEND && int'(dest_nxt) == i) send_nxt[i] = 1'b1;
    end
    if (grant) ready_nxt[gnt_id] = 1'b1;
    done_nxt[owner] = fin;
    err_nxt[owner]  = timeout;
  end

  // Registered outputs and the transfer context captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      dest       <= '0;
      dado       <= '0;
      send       <= '0;
      req_ready  <= '0;
      done       <= '0;
      err        <= '0;
      busy       <= 1'b0;
    end else begin
      if (grant) begin
        last_grant <= gnt_id;
        owner      <= gnt_id;
        dest       <= dest_sel;
        dado       <= data_sel;
      end
      send      <= send_nxt;
      req_ready <= ready_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
